// File: rtl/global_def.sv
// -----------------------------------------------------------------------------
// global_def
// Shared definitions for the instruction-fetch stage:
//   ADDR_BUS / INST_BUS : address and instruction word widths
//   ZERO_WORD           : all-zero word used to clear address registers
//   NOP_INST            : instruction presented to ID when no real one is held
//   RST_ENABLE          : level of rst that holds the design in reset (low)
//   PC_STEP             : byte distance between consecutive instruction words
//   fetch_state_e       : FETCH / HOLD / DRAIN state encoding
//   fetch_pkt_t         : {addr, inst} pair carried through the stage
//   word_align()        : clears the two byte-offset bits of an address
// -----------------------------------------------------------------------------
package global_def;

    localparam int ADDR_BUS = 32;
    localparam int INST_BUS = 32;

    localparam logic [ADDR_BUS-1:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic [INST_BUS-1:0] NOP_INST   = 32'h0000_0000;
    localparam logic                RST_ENABLE = 1'b0;
    localparam logic [ADDR_BUS-1:0] PC_STEP    = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding or about to be issued
        HOLD  = 2'd1,   // a fetched word waits in the skid buffer for ID
        DRAIN = 2'd2    // waiting to swallow the response of a flushed request
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_BUS-1:0] addr;
        logic [INST_BUS-1:0] inst;
    } fetch_pkt_t;

    function automatic logic [ADDR_BUS-1:0] word_align(input logic [ADDR_BUS-1:0] a);
        return {a[ADDR_BUS-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// -----------------------------------------------------------------------------
// if_skid_buf
// One-entry holding register for an instruction that arrived from memory while
// ID was stalled.
// Ports:
//   clk, rst             : clock, asynchronous active-low reset
//   load                 : capture load_addr / load_inst and mark the entry valid
//   clear                : invalidate the entry (wins over load)
//   load_addr, load_inst : PC and instruction word to capture
//   valid, addr, inst    : current contents of the entry
// -----------------------------------------------------------------------------
module if_skid_buf
    import global_def::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                clear,
    input  logic [ADDR_BUS-1:0] load_addr,
    input  logic [INST_BUS-1:0] load_inst,
    output logic                valid,
    output logic [ADDR_BUS-1:0] addr,
    output logic [INST_BUS-1:0] inst
);

    logic                valid_q, valid_d;
    fetch_pkt_t          pkt_q, pkt_d;

    always_comb begin
        valid_d = valid_q;
        pkt_d   = pkt_q;
        if (clear) begin
            valid_d   = 1'b0;
            pkt_d.addr = ZERO_WORD;
            pkt_d.inst = NOP_INST;
        end else if (load) begin
            valid_d    = 1'b1;
            pkt_d.addr = load_addr;
            pkt_d.inst = load_inst;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            valid_q    <= 1'b0;
            pkt_q.addr <= ZERO_WORD;
            pkt_q.inst <= NOP_INST;
        end else begin
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
        end
    end

    assign valid = valid_q;
    assign addr  = pkt_q.addr;
    assign inst  = pkt_q.inst;

endmodule

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch
// Instruction fetch stage: owns the PC, issues at most one request at a time to
// instruction memory and presents registered {addr, inst, inst_valid} to ID.
// A one-entry skid buffer absorbs a response that arrives while ID is stalled,
// and a DRAIN state swallows the response of a request that was flushed.
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   stall                     : ID not accepting; outputs to ID are held
//   flush, redirect_addr      : redirect fetch to redirect_addr (word aligned)
//   imem_req, imem_addr       : request and word address to instruction memory
//   imem_rvalid, imem_rdata   : response from memory (same cycle or later)
//   addr, inst, inst_valid    : registered instruction presented to ID
// Parameter:
//   RESET_PC                  : first fetch address after reset
// -----------------------------------------------------------------------------
module if_fetch
    import global_def::*;
#(
    parameter logic [ADDR_BUS-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic [ADDR_BUS-1:0] redirect_addr,
    output logic                imem_req,
    output logic [ADDR_BUS-1:0] imem_addr,
    input  logic                imem_rvalid,
    input  logic [INST_BUS-1:0] imem_rdata,
    output logic [ADDR_BUS-1:0] addr,
    output logic [INST_BUS-1:0] inst,
    output logic                inst_valid
);

    fetch_state_e        state_q, state_d;
    logic [ADDR_BUS-1:0] pc_q, pc_d;
    logic [ADDR_BUS-1:0] addr_q, addr_d;
    logic [INST_BUS-1:0] inst_q, inst_d;
    logic                inst_valid_q, inst_valid_d;
    // Set once a request has been presented for a full cycle without an
    // answer; a flush is then the only thing that can leave memory owing us a
    // response, which DRAIN must absorb.
    logic                outstanding_q, outstanding_d;

    logic                skid_load;
    logic                skid_clear;
    logic                skid_valid;
    logic [ADDR_BUS-1:0] skid_addr;
    logic [INST_BUS-1:0] skid_inst;
    logic [ADDR_BUS-1:0] pc_inc;

    assign pc_inc = pc_q + PC_STEP;     // wraps modulo 2^32 by construction

    // The request depends on flush combinationally so that a redirect never
    // launches a fetch from the stale PC, and on rst so that the very first
    // cycle after release already requests RESET_PC.
    assign imem_req  = (state_q == FETCH) && (rst != RST_ENABLE) && !flush;
    assign imem_addr = pc_q;

    if_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_addr (pc_q),
        .load_inst (imem_rdata),
        .valid     (skid_valid),
        .addr      (skid_addr),
        .inst      (skid_inst)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        addr_d        = addr_q;
        inst_d        = inst_q;
        inst_valid_d  = inst_valid_q;
        outstanding_d = outstanding_q;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;

        if (flush) begin
            // Redirect wins over everything, including stall.
            addr_d        = ZERO_WORD;
            inst_d        = NOP_INST;
            inst_valid_d  = 1'b0;
            skid_clear    = 1'b1;
            pc_d          = word_align(redirect_addr);
            outstanding_d = 1'b0;
            case (state_q)
                // A response arriving together with the flush settles the old
                // request; otherwise one is still owed only if it was issued.
                FETCH:   state_d = (outstanding_q && !imem_rvalid) ? DRAIN : FETCH;
                HOLD:    state_d = FETCH;
                // Stay in DRAIN unless the owed response lands in this cycle,
                // in which case nothing remains to be swallowed.
                DRAIN:   state_d = imem_rvalid ? FETCH : DRAIN;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_rvalid) begin
                        pc_d          = pc_inc;
                        outstanding_d = 1'b0;
                        if (stall) begin
                            // ID still owns the current outputs: park the word.
                            skid_load = 1'b1;
                            state_d   = HOLD;
                        end else begin
                            addr_d       = pc_q;
                            inst_d       = imem_rdata;
                            inst_valid_d = 1'b1;
                        end
                    end else begin
                        outstanding_d = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        addr_d       = skid_addr;
                        inst_d       = skid_inst;
                        inst_valid_d = skid_valid;
                        skid_clear   = 1'b1;
                        state_d      = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) begin
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            addr_q        <= ZERO_WORD;
            inst_q        <= NOP_INST;
            inst_valid_q  <= 1'b0;
            outstanding_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            addr_q        <= addr_d;
            inst_q        <= inst_d;
            inst_valid_q  <= inst_valid_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign addr       = addr_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch
// Drives if_fetch against a behavioural instruction memory with selectable
// latency and compares every cycle against a queue-based reference model of
// the fetch stage (PC, words waiting for ID, response still owed after flush).
// -----------------------------------------------------------------------------
module tb_if_fetch;
    import global_def::*;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        inst_valid;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .redirect_addr (redirect_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .addr          (addr),
        .inst          (inst),
        .inst_valid    (inst_valid)
    );

    // ---------------- instruction memory model ----------------
    int unsigned mem_lat;
    logic        mem_busy;
    int unsigned mem_cnt;
    logic [31:0] mem_addr_l;
    logic        stray_rvalid;
    logic [31:0] stray_data;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a + 32'd1;
    endfunction

    always_comb begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (stray_rvalid) begin
            imem_rvalid = 1'b1;
            imem_rdata  = stray_data;
        end else if (mem_lat == 0) begin
            imem_rvalid = imem_req;
            imem_rdata  = mem_data(imem_addr);
        end else begin
            imem_rvalid = mem_busy && (mem_cnt == 0);
            imem_rdata  = mem_data(mem_addr_l);
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            mem_busy <= 1'b0;
            mem_cnt  <= 0;
        end else if (mem_lat != 0) begin
            if (!mem_busy) begin
                if (imem_req) begin
                    mem_busy   <= 1'b1;
                    mem_cnt    <= mem_lat - 1;
                    mem_addr_l <= imem_addr;
                end
            end else if (mem_cnt == 0) begin
                mem_busy <= 1'b0;
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] i;
    } ent_t;

    logic [31:0] m_pc;
    logic [31:0] m_out_a;
    logic [31:0] m_out_i;
    logic        m_out_v;
    ent_t        m_q[$];      // fetched words not yet shown to ID
    logic        m_drain;     // a flushed request's response is still owed

    int err_count   = 0;
    int check_count = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_out_a = 32'h0;
        m_out_i = 32'h0;
        m_out_v = 1'b0;
        m_q.delete();
        m_drain = 1'b0;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input logic st, input logic fl, input logic [31:0] ra,
                        output logic got_req, output logic [31:0] got_addr);
        logic        rv;
        logic [31:0] rd;
        logic        exp_req;
        logic        delivered;
        ent_t        e;
        stall         = st;
        flush         = fl;
        redirect_addr = ra;
        #1;
        got_req   = imem_req;
        got_addr  = imem_addr;
        rv        = imem_rvalid;
        rd        = imem_rdata;
        delivered = 1'b0;
        // A new request is made only when nothing waits for ID, nothing is
        // owed from memory and no redirect is in progress.
        exp_req = !fl && (m_q.size() == 0) && !m_drain;
        check_eq("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req && imem_req)
            check_eq("imem_addr", imem_addr, m_pc);

        if (fl) begin
            m_out_v = 1'b0;
            m_out_a = 32'h0;
            m_out_i = 32'h0;
            m_q.delete();
            m_pc    = {ra[31:2], 2'b00};
            m_drain = mem_busy && !rv;
            $display("[%0t] flush -> pc=%08h", $time, m_pc);
        end else if (m_drain) begin
            if (rv) m_drain = 1'b0;
        end else if (m_q.size() != 0) begin
            if (!st) begin
                e         = m_q.pop_front();
                m_out_a   = e.a;
                m_out_i   = e.i;
                m_out_v   = 1'b1;
                delivered = 1'b1;
            end
        end else if (rv) begin
            if (st) begin
                m_q.push_back('{a: m_pc, i: rd});
            end else begin
                m_out_a   = m_pc;
                m_out_i   = rd;
                m_out_v   = 1'b1;
                delivered = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end

        @(posedge clk);
        @(negedge clk);
        check_eq("addr", addr, m_out_a);
        check_eq("inst", inst, m_out_i);
        check_eq("inst_valid", {31'b0, inst_valid}, {31'b0, m_out_v});
        if (delivered)
            $display("[%0t] ID <= addr=%08h inst=%08h", $time, m_out_a, m_out_i);
    endtask

    // Entered and left at a falling edge; leaves rst released.
    task automatic do_reset(input int unsigned lat);
        rst          = 1'b0;
        stall        = 1'b0;
        flush        = 1'b0;
        stray_rvalid = 1'b0;
        mem_lat      = lat;
        #1;
        check_eq("rst_imem_req", {31'b0, imem_req}, 32'h0);
        check_eq("rst_addr", addr, 32'h0);
        check_eq("rst_inst", inst, 32'h0);
        check_eq("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r;
        logic [31:0] a;
        logic        seen;
        logic [31:0] seen_addr;

        rst           = 1'b0;
        stall         = 1'b0;
        flush         = 1'b0;
        redirect_addr = 32'h0;
        stray_rvalid  = 1'b0;
        stray_data    = 32'h0;
        mem_lat       = 0;
        model_reset();
        @(negedge clk);

        // Same-cycle memory streams one instruction per cycle from RESET_PC.
        do_reset(0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, r, a);
            check_eq("r34_first_req", {31'b0, r}, 32'h1);
            check_eq("r34_addr", addr, RESET_PC + 32'(4 * i));
            check_eq("r34_inst", inst, RESET_PC + 32'(4 * i) + 32'd1);
            check_eq("r34_valid", {31'b0, inst_valid}, 32'h1);
        end

        // Three stall cycles while BFC00004 returns.
        do_reset(0);
        step(1'b0, 1'b0, 32'h0, r, a);
        step(1'b1, 1'b0, 32'h0, r, a);
        check_eq("r35_held", addr, 32'hBFC0_0000);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 32'h0, r, a);
            check_eq("r35_req_hold", {31'b0, r}, 32'h0);
            check_eq("r35_held", addr, 32'hBFC0_0000);
        end
        step(1'b0, 1'b0, 32'h0, r, a);
        check_eq("r35_skid_out", addr, 32'hBFC0_0004);
        step(1'b0, 1'b0, 32'h0, r, a);
        check_eq("r35_next", addr, 32'hBFC0_0008);

        // Flush while a 3-cycle request is outstanding.
        do_reset(3);
        step(1'b0, 1'b0, 32'h0, r, a);
        step(1'b0, 1'b0, 32'h0, r, a);
        step(1'b0, 1'b1, 32'h0000_1002, r, a);
        check_eq("r36_valid_after_flush", {31'b0, inst_valid}, 32'h0);
        seen      = 1'b0;
        seen_addr = 32'h0;
        for (int k = 0; k < 8 && !seen; k++) begin
            step(1'b0, 1'b0, 32'h0, r, a);
            if (r) begin
                seen      = 1'b1;
                seen_addr = a;
            end
        end
        check_eq("r36_req_seen", {31'b0, seen}, 32'h1);
        check_eq("r36_next_addr", seen_addr, 32'h0000_1000);
        check_eq("r36_stale_dropped", {31'b0, inst_valid}, 32'h0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h0, r, a);
        check_eq("r36_redirect_inst", addr, 32'h0000_1000);

        // Flush together with stall while holding a skid word.
        do_reset(0);
        step(1'b0, 1'b0, 32'h0, r, a);
        step(1'b1, 1'b0, 32'h0, r, a);
        step(1'b1, 1'b1, 32'h0000_2000, r, a);
        check_eq("r37_valid", {31'b0, inst_valid}, 32'h0);
        step(1'b0, 1'b0, 32'h0, r, a);
        check_eq("r37_req", {31'b0, r}, 32'h1);
        check_eq("r37_req_addr", a, 32'h0000_2000);
        check_eq("r37_addr", addr, 32'h0000_2000);
        check_eq("r37_inst", inst, 32'h0000_2001);

        // PC wrap at the top of the address space.
        do_reset(0);
        step(1'b0, 1'b1, 32'hFFFF_FFFC, r, a);
        step(1'b0, 1'b0, 32'h0, r, a);
        check_eq("r38_top_addr", a, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0, r, a);
        check_eq("r38_wrap_addr", a, 32'h0000_0000);

        // Reset during an outstanding request, stray rvalid while in reset.
        do_reset(3);
        step(1'b0, 1'b0, 32'h0, r, a);
        step(1'b0, 1'b0, 32'h0, r, a);
        rst = 1'b0;
        #1;
        check_eq("r39_req_in_reset", {31'b0, imem_req}, 32'h0);
        check_eq("r39_valid_in_reset", {31'b0, inst_valid}, 32'h0);
        @(negedge clk);
        stray_data   = 32'hDEAD_BEEF;
        stray_rvalid = 1'b1;
        @(posedge clk);
        #1;
        rst          = 1'b1;
        stray_rvalid = 1'b0;
        model_reset();
        #1;
        check_eq("r39_reissue_req", {31'b0, imem_req}, 32'h1);
        check_eq("r39_reissue_addr", imem_addr, RESET_PC);
        @(negedge clk);
        check_eq("r39_no_stray", {31'b0, inst_valid}, 32'h0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 32'h0, r, a);
        check_eq("r39_first_inst", addr, RESET_PC);

        // Randomized traffic for every memory latency.
        for (int lat = 0; lat < 4; lat++) begin
            do_reset(lat);
            for (int n = 0; n < 200; n++) begin
                step($urandom_range(0, 99) < 30,
                     $urandom_range(0, 99) < 7,
                     $urandom, r, a);
            end
        end

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
